wb_regfile: RTL and testbench
=============================

// Module: wb_regfile
// PURPOSE
//   Write-back stage and architectural register file of the 5-stage RV32I pipeline; sink of the MEM/WB register outputs.
//   Selects the final result (ALU / load / PC+4), aligns and extends load data, and writes x1..x31.
//   Serves two decode-stage read ports with same-cycle write-through bypass and counts retired instructions.
// PARAMETERS
//   XLEN      32  datapath width
//   NREGS     32  architectural registers; x0 hardwired to 0
//   CNT_W     64  instret counter width
// PORTS
//   clk          in   1      clock, rising edge
//   reset        in   1      asynchronous, active-high
//   valid_W      in   1      WB slot holds a real (non-bubble) instruction
//   RegWrite_W   in   1      write enable from WB control
//   ResultSrc_W  in   2      00 ALU, 01 load, 10 PC+4, 11 reserved (treated as ALU)
//   funct3_W     in   3      load size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
//   ALUResult_W  in   XLEN   ALU result; [1:0] = load byte offset
//   read_data_W  in   XLEN   raw aligned memory word
//   rd_W         in   5      destination register
//   PCplus4W     in   XLEN   link value
//   rs1_D        in   5      decode read address 1
//   rs2_D        in   5      decode read address 2
//   rd1_D        out  XLEN   read data 1 (combinational)
//   rd2_D        out  XLEN   read data 2 (combinational)
//   Result_W     out  XLEN   selected write-back value (combinational; also to hazard forwarding)
//   instret      out  CNT_W  retired instruction count
// BEHAVIOUR
//   Reset: async; all registers x0..x31 <= 0, instret <= 0; rd1_D/rd2_D therefore read 0 during and after reset.
//   Load extraction: byte = word[8*off +: 8], off = ALUResult_W[1:0]; half = word[16*ALUResult_W[1] +: 16], bit 0 ignored;
//     LB/LH sign-extend, LBU/LHU zero-extend, LW and any other funct3 pass the word unchanged.
//   Result_W: mux per ResultSrc_W; 01 uses extracted load value; 11 -> ALUResult_W.
//   Write: at rising clk, if RegWrite_W && valid_W && rd_W != 0: reg[rd_W] <= Result_W. rd_W == 0 never writes.
//   Read: rdN_D = 0 if rsN_D == 0; else Result_W if write condition true and rd_W == rsN_D (bypass, latency 0);
//     else reg[rsN_D]. Both ports may bypass the same write simultaneously.
//   instret: increments by 1 at each rising clk with valid_W = 1 (independent of RegWrite_W); wraps 2^CNT_W-1 -> 0.
//   Bubbles (valid_W = 0): no write, no bypass, no count, Result_W still driven.
//   Reset asserted mid-operation overrides any pending write/increment in that cycle.
//   No X propagation: reserved encodings resolve as stated above.
// STRUCTURE
//   rv_pkg: RESULT_ALU/LOAD/PC4 encodings, F3_LB/LH/LW/LBU/LHU constants, XLEN.
//   Sub-module load_ext (combinational: word, offset, funct3 -> extended value); rest flat.
// TESTING
//   Reset, then read all 32 regs via rs1_D/rs2_D -> all 0, instret = 0.
//   Write x5 = 0xDEADBEEF (ALU); same cycle rs1_D = 5 -> rd1_D = 0xDEADBEEF; next cycle reads from array.
//   Write rd_W = 0 with 0x12345678 -> x0 reads 0, no bypass on rs2_D = 0.
//   read_data_W = 0x80F07F01: LB off 3 -> 0xFFFFFF80; LBU off 1 -> 0x0000007F; LH off 2 -> 0xFFFF80F0; LHU off 0 -> 0x00007F01.
//   ResultSrc 10, PCplus4W = 0x104, rd_W = 1 -> x1 = 0x104; ResultSrc 11 -> ALU value written.
//   100 valid_W cycles with 20 bubbles interleaved -> instret = 100; preload 2^64-1 (force) + 1 valid -> 0; reset mid-write -> reg stays 0.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// Shared encodings for the write-back stage: result-source select and load size/sign codes.
package wb_regfile_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int CNT_W = 64;

  localparam logic [1:0] RESULT_ALU  = 2'b00;
  localparam logic [1:0] RESULT_LOAD = 2'b01;
  localparam logic [1:0] RESULT_PC4  = 2'b10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/wb_regfile_load_ext.sv
// Load data alignment and sign/zero extension from a raw memory word.
module wb_regfile_load_ext #(
  parameter int W = 32
) (
  input  logic [W-1:0] word_i,
  input  logic [1:0]   off_i,
  input  logic [2:0]   funct3_i,
  output logic [W-1:0] ext_o
);
  import wb_regfile_pkg::*;

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word_i[7:0];
    case (off_i)
      2'd1:    byte_v = word_i[15:8];
      2'd2:    byte_v = word_i[23:16];
      2'd3:    byte_v = word_i[31:24];
      default: byte_v = word_i[7:0];
    endcase
    // Halfword offset bit 0 is deliberately ignored (misaligned halves round down).
    half_v = off_i[1] ? word_i[31:16] : word_i[15:0];
  end

  always_comb begin
    ext_o = word_i;
    case (funct3_i)
      F3_LB:   ext_o = {{(W-8){byte_v[7]}}, byte_v};
      F3_LH:   ext_o = {{(W-16){half_v[15]}}, half_v};
      F3_LBU:  ext_o = {{(W-8){1'b0}}, byte_v};
      F3_LHU:  ext_o = {{(W-16){1'b0}}, half_v};
      default: ext_o = word_i;
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// RV32I write-back stage: result select, architectural register file with
// same-cycle write-through read ports, and retired-instruction counter.
module wb_regfile #(
  parameter int XLEN  = wb_regfile_pkg::XLEN,
  parameter int NREGS = wb_regfile_pkg::NREGS,
  parameter int CNT_W = wb_regfile_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_W,
  input  logic             RegWrite_W,
  input  logic [1:0]       ResultSrc_W,
  input  logic [2:0]       funct3_W,
  input  logic [XLEN-1:0]  ALUResult_W,
  input  logic [XLEN-1:0]  read_data_W,
  input  logic [4:0]       rd_W,
  input  logic [XLEN-1:0]  PCplus4W,
  input  logic [4:0]       rs1_D,
  input  logic [4:0]       rs2_D,
  output logic [XLEN-1:0]  rd1_D,
  output logic [XLEN-1:0]  rd2_D,
  output logic [XLEN-1:0]  Result_W,
  output logic [CNT_W-1:0] instret
);
  import wb_regfile_pkg::*;

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [CNT_W-1:0] instret_q;
  logic [XLEN-1:0]  load_val;
  logic             wr_en;

  wb_regfile_load_ext #(.W(XLEN)) u_load_ext (
    .word_i   (read_data_W),
    .off_i    (ALUResult_W[1:0]),
    .funct3_i (funct3_W),
    .ext_o    (load_val)
  );

  always_comb begin
    Result_W = ALUResult_W;
    case (ResultSrc_W)
      RESULT_LOAD: Result_W = load_val;
      RESULT_PC4:  Result_W = PCplus4W;
      default:     Result_W = ALUResult_W;
    endcase
  end

  // Reset masks the bypass too, so the read ports show 0 while reset is held.
  assign wr_en = RegWrite_W && valid_W && (rd_W != 5'd0) && !reset;

  always_comb begin
    rd1_D = '0;
    rd2_D = '0;
    if (rs1_D != 5'd0) rd1_D = (wr_en && rd_W == rs1_D) ? Result_W : regs_q[rs1_D];
    if (rs2_D != 5'd0) rd2_D = (wr_en && rd_W == rs2_D) ? Result_W : regs_q[rs2_D];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      instret_q <= '0;
    end else begin
      if (wr_en) regs_q[rd_W] <= Result_W;
      if (valid_W) instret_q <= instret_q + 1'b1;
    end
  end

  assign instret = instret_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile using a queue of expected values.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_W, RegWrite_W;
  logic [1:0]  ResultSrc_W;
  logic [2:0]  funct3_W;
  logic [31:0] ALUResult_W, read_data_W, PCplus4W;
  logic [4:0]  rd_W, rs1_D, rs2_D;
  logic [31:0] rd1_D, rd2_D, Result_W;
  logic [63:0] instret;

  typedef struct {
    string       name;
    logic [63:0] val;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   nchecks = 0;
  int   nerr    = 0;

  wb_regfile dut (
    .clk(clk), .reset(reset), .valid_W(valid_W), .RegWrite_W(RegWrite_W),
    .ResultSrc_W(ResultSrc_W), .funct3_W(funct3_W), .ALUResult_W(ALUResult_W),
    .read_data_W(read_data_W), .rd_W(rd_W), .PCplus4W(PCplus4W),
    .rs1_D(rs1_D), .rs2_D(rs2_D), .rd1_D(rd1_D), .rd2_D(rd2_D),
    .Result_W(Result_W), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic [1:0] src,
                       input logic [2:0] f3, input logic [31:0] alu,
                       input logic [31:0] rdata, input logic [4:0] rd,
                       input logic [31:0] pc4);
    valid_W = v; RegWrite_W = we; ResultSrc_W = src; funct3_W = f3;
    ALUResult_W = alu; read_data_W = rdata; rd_W = rd; PCplus4W = pc4;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'b00, 3'b010, 32'h0, 32'h0, 5'd0, 32'h0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    rs1_D = 5'd3; rs2_D = 5'd3;
    drive(1'b1, 1'b1, 2'b00, 3'b010, 32'h1111_2222, 32'h0, 5'd3, 32'h0);
    #3;
    sb.push_back('{"rd1_in_reset", 64'h0});
    e = sb.pop_front(); nchecks++;
    if (rd1_D !== e.val[31:0]) begin nerr++; $display("FAIL %s: got %h want %h", e.name, rd1_D, e.val[31:0]); end
    idle();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rs1_D = 5'(i); rs2_D = 5'(31 - i);
      sb.push_back('{$sformatf("reset_rd1_x%0d", i), 64'h0});
      sb.push_back('{$sformatf("reset_rd2_x%0d", 31 - i), 64'h0});
      #1;
      e = sb.pop_front(); nchecks++;
      if (rd1_D !== e.val[31:0]) begin nerr++; $display("FAIL %s: got %h want %h", e.name, rd1_D, e.val[31:0]); end
      e = sb.pop_front(); nchecks++;
      if (rd2_D !== e.val[31:0]) begin nerr++; $display("FAIL %s: got %h want %h", e.name, rd2_D, e.val[31:0]); end
    end
    sb.push_back('{"reset_instret", 64'h0});
    e = sb.pop_front(); nchecks++;
    if (instret !== e.val) begin nerr++; $display("FAIL %s: got %h want %h", e.name, instret, e.val); end
  endtask

  task automatic test_bypass();
    step();
    drive(1'b1, 1'b1, 2'b00, 3'b010, 32'hDEAD_BEEF, 32'h0, 5'd5, 32'h0);
    rs1_D = 5'd5; rs2_D = 5'd6;
    sb.push_back('{"bypass_rd1", 64'hDEAD_BEEF});
    sb.push_back('{"bypass_rd2_other", 64'h0});
    #2;
    e = sb.pop_front(); nchecks++;
    if (rd1_D !== e.val[31:0]) begin nerr++; $display("FAIL %s: got %h want %h", e.name, rd1_D, e.val[31:0]); end
    e = sb.pop_front(); nchecks++;
    if (rd2_D !== e.val[31:0]) begin nerr++; $display("FAIL %s: got %h want %h", e.name, rd2_D, e.val[31:0]); end
    step();
    idle();
    sb.push_back('{"array_x5", 64'hDEAD_BEEF});
    #2;
    e = sb.pop_front(); nchecks++;
    if (rd1_D !== e.val[31:0]) begin nerr++; $display("FAIL %s: got %h want %h", e.name, rd1_D, e.val[31:0]); end
  endtask

  task automatic test_back_to_back();
    step();
    drive(1'b1, 1'b1, 2'b00, 3'b010, 32'hCAFE_0007, 32'h0, 5'd7, 32'h0);
    rs1_D = 5'd7; rs2_D = 5'd7;
    sb.push_back('{"dual_bypass_rd1", 64'hCAFE_0007});
    sb.push_back('{"dual_bypass_rd2", 64'hCAFE_0007});
    #2;
    e = sb.pop_front(); nchecks++;
    if (rd1_D !== e.val[31:0]) begin nerr++; $display("FAIL %s: got %h want %h", e.name, rd1_D, e.val[31:0]); end
    e = sb.pop_front(); nchecks++;
    if (rd2_D !== e.val[31:0]) begin nerr++; $display("FAIL %s: got %h want %h", e.name, rd2_D, e.val[31:0]); end
    step();
    drive(1'b1, 1'b1, 2'b00, 3'b010, 32'h0BAD_F00D, 32'h0, 5'd7, 32'h0);
    rs2_D = 5'd5;
    sb.push_back('{"overwrite_bypass_rd1", 64'h0BAD_F00D});
    sb.push_back('{"other_reg_rd2", 64'hDEAD_BEEF});
    #2;
    e = sb.pop_front(); nchecks++;
    if (rd1_D !== e.val[31:0]) begin nerr++; $display("FAIL %s: got %h want %h", e.name, rd1_D, e.val[31:0]); end
    e = sb.pop_front(); nchecks++;
    if (rd2_D !== e.val[31:0]) begin nerr++; $display("FAIL %s: got %h want %h", e.name, rd2_D, e.val[31:0]); end
    // A bubble and a RegWrite=0 slot must neither bypass nor write.
    step();
    drive(1'b0, 1'b1, 2'b00, 3'b010, 32'h1357_9BDF, 32'h0, 5'd7, 32'h0);
    sb.push_back('{"bubble_no_bypass", 64'h0BAD_F00D});
    sb.push_back('{"bubble_result_driven", 64'h1357_9BDF});
    #2;
    e = sb.pop_front(); nchecks++;
    if (rd1_D !== e.val[31:0]) begin nerr++; $display("FAIL %s: got %h want %h", e.name, rd1_D, e.val[31:0]); end
    e = sb.pop_front(); nchecks++;
    if (Result_W !== e.val[31:0]) begin nerr++; $display("FAIL %s: got %h want %h", e.name, Result_W, e.val[31:0]); end
    step();
    drive(1'b1, 1'b0, 2'b00, 3'b010, 32'h2468_ACE0, 32'h0, 5'd7, 32'h0);
    step();
    idle();
    sb.push_back('{"no_write_when_we0", 64'h0BAD_F00D});
    #2;
    e = sb.pop_front(); nchecks++;
    if (rd1_D !== e.val[31:0]) begin nerr++; $display("FAIL %s: got %h want %h", e.name, rd1_D, e.val[31:0]); end
  endtask

  task automatic test_x0();
    step();
    drive(1'b1, 1'b1, 2'b00, 3'b010, 32'h1234_5678, 32'h0, 5'd0, 32'h0);
    rs1_D = 5'd0; rs2_D = 5'd0;
    sb.push_back('{"x0_no_bypass_rd2", 64'h0});
    sb.push_back('{"x0_result", 64'h1234_5678});
    #2;
    e = sb.pop_front(); nchecks++;
    if (rd2_D !== e.val[31:0]) begin nerr++; $display("FAIL %s: got %h want %h", e.name, rd2_D, e.val[31:0]); end
    e = sb.pop_front(); nchecks++;
    if (Result_W !== e.val[31:0]) begin nerr++; $display("FAIL %s: got %h want %h", e.name, Result_W, e.val[31:0]); end
    step();
    idle();
    sb.push_back('{"x0_after_write", 64'h0});
    #2;
    e = sb.pop_front(); nchecks++;
    if (rd1_D !== e.val[31:0]) begin nerr++; $display("FAIL %s: got %h want %h", e.name, rd1_D, e.val[31:0]); end
  endtask

  task automatic test_load_ext();
    logic [2:0]  f3  [10] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b001, 3'b101, 3'b100, 3'b000, 3'b010, 3'b011};
    logic [1:0]  off [10] = '{2'd3,   2'd1,   2'd2,   2'd0,   2'd3,   2'd1,   2'd2,   2'd0,   2'd0,   2'd2};
    logic [31:0] exv [10] = '{32'hFFFF_FF80, 32'h0000_007F, 32'hFFFF_80F0, 32'h0000_7F01,
                              32'hFFFF_80F0, 32'h0000_7F01, 32'h0000_00F0, 32'h0000_0001,
                              32'h80F0_7F01, 32'h80F0_7F01};
    step();
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, 2'b01, f3[i], {30'h0, off[i]}, 32'h80F0_7F01, 5'd0, 32'h0);
      sb.push_back('{$sformatf("load_f3_%0d_off_%0d", f3[i], off[i]), {32'h0, exv[i]}});
      #1;
      e = sb.pop_front(); nchecks++;
      if (Result_W !== e.val[31:0]) begin nerr++; $display("FAIL %s: got %h want %h", e.name, Result_W, e.val[31:0]); end
    end
    drive(1'b1, 1'b1, 2'b01, 3'b000, 32'h0000_1003, 32'h80F0_7F01, 5'd9, 32'h0);
    step();
    idle();
    rs1_D = 5'd9;
    sb.push_back('{"load_written_x9", 64'hFFFF_FF80});
    #2;
    e = sb.pop_front(); nchecks++;
    if (rd1_D !== e.val[31:0]) begin nerr++; $display("FAIL %s: got %h want %h", e.name, rd1_D, e.val[31:0]); end
  endtask

  task automatic test_pc4_reserved();
    step();
    drive(1'b1, 1'b1, 2'b10, 3'b010, 32'hFFFF_0000, 32'h0, 5'd1, 32'h0000_0104);
    step();
    drive(1'b1, 1'b1, 2'b11, 3'b010, 32'hA5A5_0011, 32'h5555_5555, 5'd2, 32'h0000_0200);
    step();
    idle();
    rs1_D = 5'd1; rs2_D = 5'd2;
    sb.push_back('{"pc4_x1", 64'h104});
    sb.push_back('{"reserved_src_x2", 64'hA5A5_0011});
    #2;
    e = sb.pop_front(); nchecks++;
    if (rd1_D !== e.val[31:0]) begin nerr++; $display("FAIL %s: got %h want %h", e.name, rd1_D, e.val[31:0]); end
    e = sb.pop_front(); nchecks++;
    if (rd2_D !== e.val[31:0]) begin nerr++; $display("FAIL %s: got %h want %h", e.name, rd2_D, e.val[31:0]); end
  endtask

  task automatic test_instret();
    int model = 0;
    step();
    reset = 1'b1;
    idle();
    #2 reset = 1'b0;
    for (int i = 0; i < 120; i++) begin
      step();
      drive((i % 6) != 5, 1'(i & 1), 2'b00, 3'b010, 32'(i), 32'h0, 5'd20, 32'h0);
      if ((i % 6) != 5) model++;
    end
    step();
    idle();
    sb.push_back('{"instret_100", 64'(model)});
    sb.push_back('{"instret_const_100", 64'd100});
    #2;
    e = sb.pop_front(); nchecks++;
    if (instret !== e.val) begin nerr++; $display("FAIL %s: got %0d want %0d", e.name, instret, e.val); end
    e = sb.pop_front(); nchecks++;
    if (instret !== e.val) begin nerr++; $display("FAIL %s: got %0d want %0d", e.name, instret, e.val); end
  endtask

  task automatic test_wrap();
    idle();
    #1;
    force dut.instret_q = {64{1'b1}};
    #1;
    release dut.instret_q;
    #1;
    sb.push_back('{"instret_preload", {64{1'b1}}});
    e = sb.pop_front(); nchecks++;
    if (instret !== e.val) begin nerr++; $display("FAIL %s: got %h want %h", e.name, instret, e.val); end
    valid_W = 1'b1;
    step();
    idle();
    sb.push_back('{"instret_wrap", 64'h0});
    #2;
    e = sb.pop_front(); nchecks++;
    if (instret !== e.val) begin nerr++; $display("FAIL %s: got %h want %h", e.name, instret, e.val); end
  endtask

  task automatic test_reset_mid_write();
    step();
    drive(1'b1, 1'b1, 2'b00, 3'b010, 32'h0000_0055, 32'h0, 5'd12, 32'h0);
    rs1_D = 5'd12;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back('{"reset_masks_bypass", 64'h0});
    e = sb.pop_front(); nchecks++;
    if (rd1_D !== e.val[31:0]) begin nerr++; $display("FAIL %s: got %h want %h", e.name, rd1_D, e.val[31:0]); end
    idle();
    reset = 1'b0;
    #2;
    sb.push_back('{"reset_mid_write_x12", 64'h0});
    sb.push_back('{"reset_mid_write_instret", 64'h0});
    e = sb.pop_front(); nchecks++;
    if (rd1_D !== e.val[31:0]) begin nerr++; $display("FAIL %s: got %h want %h", e.name, rd1_D, e.val[31:0]); end
    e = sb.pop_front(); nchecks++;
    if (instret !== e.val) begin nerr++; $display("FAIL %s: got %h want %h", e.name, instret, e.val); end
  endtask

  initial begin
    rs1_D = 5'd0; rs2_D = 5'd0;
    test_reset();
    test_bypass();
    test_back_to_back();
    test_x0();
    test_load_ext();
    test_pc4_reserved();
    test_instret();
    test_wrap();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
